// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse letter sequencer: FSM states,
// default geometry, and the eight 13-bit letter light patterns.
package morse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETSEL,
      ST_STROBE,
      ST_SHIFT,
      ST_GAP
   } state_e;

   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_CODE_W     = 3;
   localparam int DEF_SYMBOL_LEN = 13;
   localparam int DEF_GAP_TICKS  = 3;

   // Left-justified on/off light patterns: dot = 1, dash = 111, 0 between elements.
   localparam logic [12:0] PATTERNS [8] = '{
      13'b1000000000000,   // E
      13'b1110000000000,   // T
      13'b1011100000000,   // A
      13'b1110100000000,   // N
      13'b1010000000000,   // I
      13'b1110111000000,   // M
      13'b1010100000000,   // S
      13'b1110111011100    // O
   };

   function automatic logic [12:0] pattern_of(input logic [2:0] letter);
      return PATTERNS[letter];
   endfunction

endpackage

// File: rtl/morse_code_fifo.sv
// Small synchronous FIFO of letter codes with flush, full/empty flags and
// an occupancy count; a push while full is dropped even if a pop coincides.
module morse_code_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 3,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = mem_q[rd_ptr_q];

   // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      do_push  = push & ~full & ~flush;
      do_pop   = pop & ~empty & ~flush;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: storage is not reset; the empty level guarantees stale entries are never read.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/morse_sequencer.sv
// Plays queued Morse letters: selects the pattern, strobes the shift-register
// load, shifts once per tick, then idles for an inter-letter gap.
module morse_sequencer
   import morse_pkg::*;
#(
   parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter  int CODE_W     = DEF_CODE_W,
   parameter  int SYMBOL_LEN = DEF_SYMBOL_LEN,
   parameter  int GAP_TICKS  = DEF_GAP_TICKS,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              tick,
   input  logic              push,
   input  logic [CODE_W-1:0] code,
   output logic              ready,
   input  logic              abort,
   output logic [CODE_W-1:0] sel,
   output logic              load_n,
   output logic              shift_en,
   output logic              clear,
   output logic              busy,
   output logic              done,
   output logic [LVL_W-1:0]  level
);

   localparam int SYM_W = $clog2(SYMBOL_LEN);
   localparam int GAP_W = $clog2(GAP_TICKS + 2);
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMBOL_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   state_e            state_q, state_d;
   logic [CODE_W-1:0] sel_q, sel_d;
   logic [SYM_W-1:0]  sym_q, sym_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              clear_q, clear_d;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CODE_W-1:0] fifo_head;

   morse_code_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .flush  (abort),
      .push   (push),
      .pop    (pop),
      .din    (code),
      .dout   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (level)
   );

   assign ready  = ~fifo_full;
   assign sel    = sel_q;
   assign load_n = (state_q != ST_STROBE);
   assign clear  = clear_q;
   assign busy   = (state_q != ST_IDLE);

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      sym_d    = sym_q;
      gap_d    = gap_q;
      clear_d  = 1'b0;
      pop      = 1'b0;
      shift_en = 1'b0;
      done     = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         sym_d   = '0;
         gap_d   = '0;
         clear_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_SETSEL;
            ST_SETSEL: begin
               pop     = 1'b1;
               sel_d   = fifo_head;
               state_d = ST_STROBE;
            end
            ST_STROBE: state_d = ST_SHIFT;
            // The final tick of a letter ends its display instead of shifting.
            ST_SHIFT: if (tick) begin
               if (sym_q == SYM_LAST) begin
                  sym_d = '0;
                  if (GAP_TICKS > 0)    state_d = ST_GAP;
                  else if (!fifo_empty) state_d = ST_SETSEL;
                  else begin
                     state_d = ST_IDLE;
                     done    = 1'b1;
                  end
               end else begin
                  sym_d    = sym_q + SYM_W'(1);
                  shift_en = 1'b1;
               end
            end
            ST_GAP: if (tick) begin
               if (gap_q == GAP_LAST) begin
                  gap_d = '0;
                  if (!fifo_empty) state_d = ST_SETSEL;
                  else begin
                     state_d = ST_IDLE;
                     done    = 1'b1;
                  end
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         sym_q   <= '0;
         gap_q   <= '0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         sym_q   <= sym_d;
         gap_q   <= gap_d;
         clear_q <= clear_d;
      end
   end

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: reset and FIFO vector table, directed multi-cycle
// sequences, and randomized traffic checked by a queue-based letter model.
module tb_morse_sequencer;
   import morse_pkg::*;

   localparam int DEPTH = 4;
   localparam int SL    = 13;
   localparam int GT    = 3;

   logic       clock, resetn, tick, push, abort;
   logic [2:0] code;
   logic       ready, load_n, shift_en, clear, busy, done;
   logic [2:0] sel, level;

   logic       push0;
   logic [2:0] code0;
   logic       z_ready, z_load_n, z_shift_en, z_clear, z_busy, z_done;
   logic [2:0] z_sel, z_level;

   int errors = 0;
   int checks = 0;

   morse_sequencer #(.FIFO_DEPTH(DEPTH), .CODE_W(3), .SYMBOL_LEN(SL), .GAP_TICKS(GT)) dut (
      .clock(clock), .resetn(resetn), .tick(tick), .push(push), .code(code), .ready(ready),
      .abort(abort), .sel(sel), .load_n(load_n), .shift_en(shift_en), .clear(clear),
      .busy(busy), .done(done), .level(level));

   morse_sequencer #(.FIFO_DEPTH(DEPTH), .CODE_W(3), .SYMBOL_LEN(SL), .GAP_TICKS(0)) dut_g0 (
      .clock(clock), .resetn(resetn), .tick(tick), .push(push0), .code(code0), .ready(z_ready),
      .abort(abort), .sel(z_sel), .load_n(z_load_n), .shift_en(z_shift_en), .clear(z_clear),
      .busy(z_busy), .done(z_done), .level(z_level));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic p, input logic [2:0] c, input logic a, input logic t);
      push  = p;
      code  = c;
      abort = a;
      tick  = t;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      push0 = 1'b0;
      code0 = 3'd0;
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   // Letter-level model of the main instance: a queue of accepted codes plus
   // per-letter tick and shift accounting between load strobes.
   logic [2:0] mq[$];
   logic       exp_clear = 1'b0, exp_idle = 1'b0, active = 1'b0, prev_tick = 1'b0;
   int         letter_ticks = 0, letter_shifts = 0, letters_played = 0;

   always @(negedge clock) begin
      if (!resetn) begin
         mq.delete();
         exp_clear = 1'b0; exp_idle = 1'b0; active = 1'b0; prev_tick = 1'b0;
         letter_ticks = 0; letter_shifts = 0;
      end else begin
         check("mon clear", clear, exp_clear);
         if (exp_idle) check("mon busy after end", busy, 0);
         if (!load_n) begin
            check("mon strobe has queued code", 32'(mq.size() != 0), 1);
            if (mq.size() != 0) begin
               check("mon sel order", sel, mq[0]);
               void'(mq.pop_front());
            end
            if (active) begin
               check("mon letter ticks", letter_ticks - int'(prev_tick), SL + GT);
               check("mon letter shifts", letter_shifts, SL - 1);
               letters_played++;
            end
            active = 1'b1; letter_ticks = 0; letter_shifts = 0;
         end else if (active) begin
            letter_ticks  += int'(tick);
            letter_shifts += int'(shift_en);
         end else begin
            check("mon shift outside letter", shift_en, 0);
         end
         if (done) begin
            check("mon done legit", 32'(active && !abort && mq.size() == 0 &&
                  letter_ticks == SL + GT && letter_shifts == SL - 1), 1);
            if (active) letters_played++;
            active = 1'b0;
         end
         if (active && letter_ticks > SL + GT + 1) begin
            check("mon letter overrun", letter_ticks, SL + GT);
            active = 1'b0;
         end
         check("mon level", level, mq.size());
         check("mon ready", ready, 32'(mq.size() != DEPTH));
         exp_idle  = done | abort;
         exp_clear = abort;
         if (abort) begin
            mq.delete();
            active = 1'b0;
         end else if (push && mq.size() < DEPTH) begin
            mq.push_back(code);
         end
         prev_tick = tick;
      end
   end

   typedef struct {
      logic       push;
      logic [2:0] code;
      logic       abort;
      logic [2:0] e_sel;
      logic       e_load_n, e_clear, e_busy, e_ready;
      logic [2:0] e_level;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int strobes, shifts, lt, dones, n, ns, zs, zd, zshifts, ab_cyc, busy_cnt, t13a, t13b, dcyc, cnt;
      logic [2:0] sel_seen;
      logic [2:0] order [4];
      logic [2:0] lvl [4];
      logic       aborted;
      logic [2:0] codes [3];
      int         scyc [4];
      int         tq[$];

      resetn = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      push0 = 1'b0;
      code0 = 3'd0;

      //            push  code abort sel  ld_n clr busy rdy level
      tbl[0] = '{1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
      tbl[1] = '{1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
      tbl[2] = '{1'b1, 3'd7, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
      tbl[3] = '{1'b1, 3'd1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3};
      tbl[4] = '{1'b1, 3'd2, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
      tbl[5] = '{1'b1, 3'd6, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
      tbl[6] = '{1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};
      tbl[7] = '{1'b1, 3'd4, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};
      tbl[8] = '{1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};

      // Reset state of every output.
      do_reset();
      check("reset outputs", {sel, load_n, shift_en, clear, busy, done, ready, level},
            {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});

      // FIFO fill, overflow drop, abort flush and abort-cycle push discard (tick held low).
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].push, tbl[i].code, tbl[i].abort, 1'b0);
         step();
         check($sformatf("vec%0d", i), {sel, load_n, clear, busy, ready, level},
               {tbl[i].e_sel, tbl[i].e_load_n, tbl[i].e_clear, tbl[i].e_busy, tbl[i].e_ready, tbl[i].e_level});
      end
      drive(1'b0, 3'd0, 1'b0, 1'b0);

      // Single letter, tick every 10 cycles.
      do_reset();
      drive(1'b1, 3'd3, 1'b0, 1'b0);
      strobes = 0; shifts = 0; lt = 0; dones = 0; sel_seen = 3'd0;
      for (int cyc = 1; cyc < 600; cyc++) begin
         step();
         drive(1'b0, 3'd0, 1'b0, (cyc % 10) == 0);
         @(negedge clock);
         if (!load_n) begin
            strobes++;
            sel_seen = sel;
         end else if (strobes > 0 && dones == 0) begin
            lt += int'(tick);
         end
         shifts += int'(shift_en);
         if (done) dones++;
         if (dones != 0) break;
      end
      step();
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clock);
      check("single strobes", strobes, 1);
      check("single sel", sel_seen, 3);
      check("single shifts", shifts, SL - 1);
      check("single letter ticks", lt, SL + GT);
      check("single done", dones, 1);
      check("single busy after", busy, 0);

      // Back-to-back 1, 5, 7.
      do_reset();
      codes[0] = 3'd1; codes[1] = 3'd5; codes[2] = 3'd7;
      ns = 0; dones = 0; cnt = 0;
      for (int k = 0; k < 4; k++) begin
         order[k] = 3'd0;
         lvl[k]   = 3'd0;
      end
      for (int cyc = 0; cyc < 1000; cyc++) begin
         step();
         drive(cyc < 3, (cyc < 3) ? codes[cyc] : 3'd0, 1'b0, (cyc % 4) == 3);
         @(negedge clock);
         if (!load_n) begin
            if (ns < 4) begin
               order[ns] = sel;
               lvl[ns]   = level;
            end
            ns++;
         end
         if (done) begin
            dones++;
            cnt = ns;
         end
         if (dones != 0 && cyc > 300) break;
      end
      check("b2b order", {order[0], order[1], order[2]}, {3'd1, 3'd5, 3'd7});
      check("b2b levels at strobes", {lvl[0], lvl[1], lvl[2]}, {3'd2, 3'd1, 3'd0});
      check("b2b strobes", ns, 3);
      check("b2b done count", dones, 1);
      check("b2b strobes before done", cnt, 3);
      check("b2b final level", level, 0);

      // Abort at the 6th tick of letter 2 with one letter queued, push held in that cycle.
      do_reset();
      codes[0] = 3'd2; codes[1] = 3'd4; codes[2] = 3'd6;
      ns = 0; n = 0; dones = 0; aborted = 1'b0; ab_cyc = -10;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         step();
         drive(cyc < 3, (cyc < 3) ? codes[cyc] : 3'd0, 1'b0, (cyc % 4) == 3);
         if (ns == 2 && tick && !aborted) begin
            n++;
            if (n == 6) begin
               drive(1'b1, 3'd5, 1'b1, 1'b1);
               aborted = 1'b1;
               ab_cyc  = cyc;
            end
         end
         @(negedge clock);
         if (!load_n) ns++;
         if (done) dones++;
         if (cyc == ab_cyc) check("abort queued before", level, 1);
         if (cyc == ab_cyc + 1) check("abort next cycle", {clear, busy, load_n, level}, {1'b1, 1'b0, 1'b1, 3'd0});
         if (cyc == ab_cyc + 2) check("abort clear one cycle", clear, 0);
         if (aborted && cyc == ab_cyc + 80) break;
      end
      check("abort reached", aborted, 1);
      check("abort no further strobes", ns, 2);
      check("abort no done", dones, 0);
      check("abort push discarded", level, 0);

      // GAP_TICKS = 0 instance: next load strobe right after the 13th tick.
      do_reset();
      zs = 0; zd = 0; zshifts = 0; dcyc = -1; tq.delete();
      for (int k = 0; k < 4; k++) scyc[k] = -1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         step();
         drive(1'b0, 3'd0, 1'b0, (cyc % 4) == 3);
         push0 = (cyc < 2);
         code0 = (cyc == 0) ? 3'd3 : 3'd6;
         @(negedge clock);
         if (!z_load_n) begin
            if (zs < 4) scyc[zs] = cyc;
            zs++;
         end
         if (tick) tq.push_back(cyc);
         zshifts += int'(z_shift_en);
         if (z_done) begin
            zd++;
            dcyc = cyc;
         end
         if (dcyc >= 0 && cyc >= dcyc + 20) break;
      end
      t13a = -1; t13b = -1; cnt = 0;
      foreach (tq[k]) if (scyc[0] >= 0 && tq[k] > scyc[0] && t13a < 0) begin
         cnt++;
         if (cnt == SL) t13a = tq[k];
      end
      cnt = 0;
      foreach (tq[k]) if (scyc[1] >= 0 && tq[k] > scyc[1] && t13b < 0) begin
         cnt++;
         if (cnt == SL) t13b = tq[k];
      end
      check("gap0 strobes", zs, 2);
      check("gap0 second strobe timing", scyc[1], t13a + 2);
      check("gap0 done timing", dcyc, t13b);
      check("gap0 done count", zd, 1);
      check("gap0 shifts", zshifts, 2 * (SL - 1));
      check("gap0 second sel", z_sel, 6);
      check("gap0 idle after", {z_ready, z_busy, z_clear, z_level}, {1'b1, 1'b0, 1'b0, 3'd0});
      push0 = 1'b0;

      // Asynchronous reset during GAP with two letters queued.
      do_reset();
      codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd3;
      ns = 0; n = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         step();
         drive(cyc < 3, (cyc < 3) ? codes[cyc] : 3'd0, 1'b0, (cyc % 4) == 3);
         if (ns == 1 && tick) n++;
         @(negedge clock);
         if (!load_n) ns++;
         if (n == SL + 1) break;
      end
      check("gap reached", n, SL + 1);
      check("queued before reset", {busy, level}, {1'b1, 3'd2});
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      @(posedge clock);
      #3 resetn = 1'b0;
      #1;
      check("mid-gap reset outputs", {sel, load_n, shift_en, clear, busy, done, ready, level},
            {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
      busy_cnt = 0; ns = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         step();
         drive(1'b0, 3'd0, 1'b0, (cyc % 4) == 3);
         @(negedge clock);
         busy_cnt += int'(busy);
         if (!load_n) ns++;
      end
      check("post reset stays idle", {busy_cnt[7:0], ns[7:0], level}, {8'd0, 8'd0, 3'd0});

      // Randomized traffic checked by the letter model.
      do_reset();
      letters_played = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         step();
         drive(($urandom % 5) == 0, 3'($urandom % 8), ($urandom % 500) == 0, ($urandom % 4) == 0);
      end
      step();
      drive(1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clock);
      check("random letters played", 32'(letters_played >= 20), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
